// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

   localparam int DMEM_ADDR_W = 32;
   localparam int DMEM_DATA_W = 32;

   // Which requester owns an access (also the round-robin pointer value).
   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DBG = 1'b1
   } owner_t;

   // Access FSM: ACCESS means mem_en is driven this cycle.
   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker; the last-grant pointer lives here.
// Latency: combinational pick, pointer updates on the edge that accepts the pick.
// Backpressure: none; the loser simply keeps requesting and wins next time.
module dmem_arbiter_rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_cpu_i,
   input  logic req_dbg_i,
   output logic gnt_cpu_o,
   output logic gnt_dbg_o
);

   owner_t last_q, last_d;

   // Pick: a lone requester wins; on a tie the side not granted last wins.
   always_comb begin
      gnt_cpu_o = req_cpu_i & (~req_dbg_i | (last_q == OWN_DBG));
      gnt_dbg_o = req_dbg_i & ~gnt_cpu_o;
      last_d    = last_q;
      if (gnt_cpu_o) begin
         last_d = OWN_CPU;
      end else if (gnt_dbg_o) begin
         last_d = OWN_DBG;
      end
   end

   // Pointer register; reset to DBG so the cpu wins the first tie.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_q <= OWN_DBG;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between cpu and debug/loader requesters.
// Latency: req edge -> registered mem access + gnt; read data returns one edge later.
// Backpressure: losing requester holds req and is served on the next access.
// Optional: DMEM_ARB_DONE_DETECT_EN adds sticky done/done_data on writes to DONE_ADDR.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int                ADDR_W    = DMEM_ADDR_W,
   parameter int                DATA_W    = DMEM_DATA_W,
   parameter logic [ADDR_W-1:0] DONE_ADDR = 32'h0000_00FC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef DMEM_ARB_DONE_DETECT_EN
   output logic              done,
   output logic [DATA_W-1:0] done_data,
`endif
   output logic              busy
);

   state_t            state_q, state_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              cpu_gnt_q, cpu_gnt_d;
   logic              dbg_gnt_q, dbg_gnt_d;
   owner_t            owner_q, owner_d;
   logic              rd_pending_q, rd_pending_d;
   owner_t            rd_owner_q, rd_owner_d;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dbg_rdata_q;
   logic              pick_cpu, pick_dbg;

   dmem_arbiter_rr_arb2 u_arb (
      .clk       (clk),
      .reset     (reset),
      .req_cpu_i (cpu_req),
      .req_dbg_i (dbg_req),
      .gnt_cpu_o (pick_cpu),
      .gnt_dbg_o (pick_dbg)
   );

   // Next state: latch the winner's fields into the memory-side registers.
   always_comb begin
      state_d     = S_IDLE;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_gnt_d   = 1'b0;
      dbg_gnt_d   = 1'b0;
      owner_d     = owner_q;
      if (pick_cpu) begin
         state_d     = S_ACCESS;
         mem_we_d    = cpu_we;
         mem_addr_d  = cpu_addr;
         mem_wdata_d = cpu_wdata;
         cpu_gnt_d   = 1'b1;
         owner_d     = OWN_CPU;
      end else if (pick_dbg) begin
         state_d     = S_ACCESS;
         mem_we_d    = dbg_we;
         mem_addr_d  = dbg_addr;
         mem_wdata_d = dbg_wdata;
         dbg_gnt_d   = 1'b1;
         owner_d     = OWN_DBG;
      end
      // A read issued this cycle returns data next cycle to its owner.
      rd_pending_d = (state_q == S_ACCESS) & ~mem_we_q;
      rd_owner_d   = owner_q;
   end

   // State and registered memory-side outputs; reset drops any pending read.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_gnt_q    <= 1'b0;
         dbg_gnt_q    <= 1'b0;
         owner_q      <= OWN_CPU;
         rd_pending_q <= 1'b0;
         rd_owner_q   <= OWN_CPU;
      end else begin
         state_q      <= state_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_gnt_q    <= cpu_gnt_d;
         dbg_gnt_q    <= dbg_gnt_d;
         owner_q      <= owner_d;
         rd_pending_q <= rd_pending_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   // Remember the last returned word per port so rdata holds between returns.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
         if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
      end
   end

   // Read return steering: memory data passes straight through to the owner.
   always_comb begin
      cpu_rvalid = rd_pending_q & (rd_owner_q == OWN_CPU);
      dbg_rvalid = rd_pending_q & (rd_owner_q == OWN_DBG);
      cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
      dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;
   end

   assign mem_en    = (state_q == S_ACCESS);
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_gnt   = cpu_gnt_q;
   assign dbg_gnt   = dbg_gnt_q;
   assign busy      = mem_en | rd_pending_q;

`ifdef DMEM_ARB_DONE_DETECT_EN
   logic              done_q;
   logic [DATA_W-1:0] done_data_q;

   // Sticky completion flag; a later qualifying write refreshes the data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         done_q      <= 1'b0;
         done_data_q <= '0;
      end else if (mem_en && mem_we_q && (mem_addr_q == DONE_ADDR)) begin
         done_q      <= 1'b1;
         done_data_q <= mem_wdata_q;
      end
   end

   assign done      = done_q;
   assign done_data = done_data_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
// Latency: inputs driven 1 time unit after each rising edge, outputs checked there.
// Backpressure: exercised through held requests under contention.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [31:0] cpu_rdata, dbg_rdata;
   logic        mem_en, mem_we, busy;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
`ifdef DMEM_ARB_DONE_DETECT_EN
   logic        done;
   logic [31:0] done_data;
`endif

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem_m [0:63];

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
`ifdef DMEM_ARB_DONE_DETECT_EN
      .done       (done),
      .done_data  (done_data),
`endif
      .busy       (busy)
   );

   // Single-port memory model: read data appears the cycle after mem_en.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem_m[mem_addr[7:2]] <= mem_wdata;
         else        mem_rdata <= mem_m[mem_addr[7:2]];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle_inputs();
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      tick();
      cpu_req = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
      mem_m[0] = 32'h1111_0000;
      mem_m[1] = 32'h2222_0004;
      mem_m[4] = 32'hDEAD_BEEF;
      #2;
      do_reset();

      // Reset state
      check_val("rst_mem_en", {31'b0, mem_en}, 32'd0);
      check_val("rst_gnts", {30'b0, cpu_gnt, dbg_gnt}, 32'd0);
      check_val("rst_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'd0);
      check_val("rst_cpu_rdata", cpu_rdata, 32'd0);
      check_val("rst_mem_addr", mem_addr, 32'd0);
      check_val("rst_busy", {31'b0, busy}, 32'd0);

      // cpu write only
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h7;
      tick();
      check_val("wr_mem_en", {31'b0, mem_en}, 32'd1);
      check_val("wr_mem_we", {31'b0, mem_we}, 32'd1);
      check_val("wr_mem_addr", mem_addr, 32'h40);
      check_val("wr_mem_wdata", mem_wdata, 32'h7);
      check_val("wr_gnts", {30'b0, cpu_gnt, dbg_gnt}, 32'b10);
      cpu_req = 1'b0;
      tick();
      check_val("wr_no_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'd0);
      check_val("wr_idle_mem_en", {31'b0, mem_en}, 32'd0);
      check_val("wr_idle_busy", {31'b0, busy}, 32'd0);

      // dbg read of 0x10
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
      tick();
      check_val("dr_gnts", {30'b0, cpu_gnt, dbg_gnt}, 32'b01);
      check_val("dr_mem_we", {31'b0, mem_we}, 32'd0);
      check_val("dr_rvalid_early", {30'b0, cpu_rvalid, dbg_rvalid}, 32'd0);
      dbg_req = 1'b0;
      tick();
      check_val("dr_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'b01);
      check_val("dr_rdata", dbg_rdata, 32'hDEAD_BEEF);
      check_val("dr_busy_ret", {31'b0, busy}, 32'd1);
      tick();
      check_val("dr_rvalid_off", {31'b0, dbg_rvalid}, 32'd0);
      check_val("dr_rdata_hold", dbg_rdata, 32'hDEAD_BEEF);
      check_val("dr_busy_off", {31'b0, busy}, 32'd0);

      // Contention from reset: cpu, dbg, cpu, dbg
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h1;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h84; dbg_wdata = 32'h2;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_val($sformatf("ct_gnts_%0d", k), {30'b0, cpu_gnt, dbg_gnt},
                   (k % 2 == 0) ? 32'b10 : 32'b01);
         check_val($sformatf("ct_mem_en_%0d", k), {31'b0, mem_en}, 32'd1);
         check_val($sformatf("ct_addr_%0d", k), mem_addr,
                   (k % 2 == 0) ? 32'h80 : 32'h84);
      end
      idle_inputs();
      tick();
      check_val("ct_release", {29'b0, mem_en, cpu_gnt, dbg_gnt}, 32'd0);

      // Back-to-back cpu reads of 0x0 and 0x4
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
      tick();
      check_val("bb_gnt0", {31'b0, cpu_gnt}, 32'd1);
      check_val("bb_addr0", mem_addr, 32'h0);
      cpu_addr = 32'h4;
      tick();
      check_val("bb_gnt1", {31'b0, cpu_gnt}, 32'd1);
      check_val("bb_addr1", mem_addr, 32'h4);
      check_val("bb_rv0", {30'b0, cpu_rvalid, dbg_rvalid}, 32'b10);
      check_val("bb_rd0", cpu_rdata, 32'h1111_0000);
      check_val("bb_busy0", {31'b0, busy}, 32'd1);
      cpu_req = 1'b0;
      tick();
      check_val("bb_rv1", {30'b0, cpu_rvalid, dbg_rvalid}, 32'b10);
      check_val("bb_rd1", cpu_rdata, 32'h2222_0004);
      check_val("bb_busy1", {31'b0, busy}, 32'd1);
      tick();
      check_val("bb_rv_off", {31'b0, cpu_rvalid}, 32'd0);
      check_val("bb_rd_hold", cpu_rdata, 32'h2222_0004);

      // Reset in the cycle of a read access: no return afterwards
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      tick();
      check_val("mr_access", {31'b0, mem_en}, 32'd1);
      reset = 1'b0;
      idle_inputs();
      tick();
      check_val("mr_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'd0);
      check_val("mr_outs", {28'b0, mem_en, mem_we, cpu_gnt, dbg_gnt}, 32'd0);
      check_val("mr_cpu_rdata", cpu_rdata, 32'd0);
      check_val("mr_mem_addr", mem_addr, 32'd0);
      check_val("mr_busy", {31'b0, busy}, 32'd0);
      tick();
      check_val("mr_rvalid2", {30'b0, cpu_rvalid, dbg_rvalid}, 32'd0);
      reset = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h88;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h8C;
      tick();
      check_val("mr_first_tie", {30'b0, cpu_gnt, dbg_gnt}, 32'b10);
      idle_inputs();
      tick();

`ifdef DMEM_ARB_DONE_DETECT_EN
      check_val("dn_init", {31'b0, done}, 32'd0);
      cpu_write(32'hFC, 32'd22);
      check_val("dn_set", {31'b0, done}, 32'd1);
      check_val("dn_data", done_data, 32'd22);
      cpu_write(32'h64, 32'd5);
      check_val("dn_sticky", {31'b0, done}, 32'd1);
      check_val("dn_data_keep", done_data, 32'd22);
      do_reset();
      cpu_write(32'h64, 32'd5);
      check_val("dn_other_addr", {31'b0, done}, 32'd0);
`else
      cpu_write(32'hFC, 32'd22);
      check_val("nd_idle", {31'b0, mem_en}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the ARM core data port (cpu) and a debug/loader port (dbg).
- The debug/loader port is used by benches to preload or inspect memory while the core runs.
- Sits between the core/top and the data memory.
- Round-robin arbitration, registered memory-side outputs, one-cycle read return routed back to the owning requester.

Parameters:
ADDR_W, 32, width of word-aligned byte address
DATA_W, 32, data width
DONE_ADDR, 32'h0000_00FC, address whose write is flagged as program completion (optional feature only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low (0 = reset, sampled on rising clk)
cpu_req  in  1  cpu access request; hold with fields stable until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  write data
cpu_gnt  out  1  one-cycle pulse: request accepted, memory access in progress this cycle
cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
cpu_rdata  out  DATA_W  read data
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as cpu_* for debug port
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0
busy  out  1  high while mem_en or a read return is pending

Behaviour:
- Reset (reset=0 at edge):
  - all outputs 0; rdata outputs 0.
  - FSM goes to IDLE; last-grant pointer = DBG, so cpu wins the first tie.
  - Any pending read is discarded: no rvalid after reset.
- FSM states:
  - IDLE: no access issued.
  - ACCESS: mem_en=1 and one gnt high for exactly this cycle.
- Transitions, evaluated each rising edge with reset=1:
  - Any req high → ACCESS. mem_* are registered from the winner's fields, winner's gnt=1, owner recorded.
  - No req → IDLE.
  - ACCESS → ACCESS is legal, giving back-to-back accesses, one per cycle.
- Arbitration:
  - Single req wins.
  - If both are high, the requester not granted last wins, and the pointer updates to the winner.
  - A req sampled while its own gnt is high is treated as a new transaction. The requester must drop req or present new fields in its gnt cycle.
- Read return:
  - ACCESS with mem_we=0 sets rd_pending and rd_owner.
  - Next cycle: owner's rvalid=1, owner's rdata=mem_rdata (combinational pass, zero added latency). The other port's rvalid stays 0.
  - Total latency req-sampled edge → rvalid = 2 edges.
  - A read return and a new ACCESS may overlap in the same cycle.
- Writes produce no rvalid.
- rdata outputs hold their last value when rvalid=0.
- Losing requester keeps req high and is served next cycle. No starvation: worst-case wait is 1 access.
- Addresses are passed unmodified: no alignment check, no wrap handling.
- busy = mem_en | rd_pending.

Optional Feature:
- Macro DMEM_ARB_DONE_DETECT_EN.
- Defined:
  - Adds outputs done (1) and done_data (DATA_W).
  - On an ACCESS cycle with mem_we=1 and mem_addr==DONE_ADDR from either port, done is set sticky next cycle and done_data captures mem_wdata.
  - Both are cleared only by reset.
  - A second qualifying write updates done_data.
- Undefined: ports absent, no logic.

Decomposition:
- Package dmem_arb_pkg:
  - owner_t enum {OWN_CPU, OWN_DBG}
  - state_t enum {S_IDLE, S_ACCESS}
  - default ADDR_W/DATA_W constants
- One natural sub-module: rr_arb2, a two-input round-robin picker holding the last-grant pointer.
- Read-return steering stays in the top module.

Test Plan:
- cpu write only: cpu_req=1, we=1, addr=0x40, wdata=0x7, released after gnt → next edge mem_en=1, mem_we=1, mem_addr=0x40, mem_wdata=0x7, cpu_gnt=1, dbg_gnt=0; no rvalid.
- dbg read: dbg_req, addr=0x10; memory model returns 0xDEADBEEF → dbg_rvalid=1 with dbg_rdata=0xDEADBEEF exactly 2 edges after request sampled; cpu_rvalid stays 0.
- Contention:
  - Both req held for 4 accesses from reset → grant order cpu, dbg, cpu, dbg.
  - Each gnt is a single-cycle pulse.
  - mem_en is continuous for 4 cycles.
- Back-to-back reads: cpu reads 0x0 then 0x4 on consecutive cycles → two consecutive cpu_rvalid pulses with matching data; busy high throughout.
- Reset mid-operation: assert reset=0 in the cycle after a read ACCESS → no rvalid, all outputs 0 next edge; first post-reset tie goes to cpu.
- DONE_DETECT_EN defined: cpu writes 22 to 0xFC → done=1 next cycle, done_data=22, remains after further traffic; write to 0x64 leaves done=0.
